// File: rtl/led_pattern_engine.sv
// -----------------------------------------------------------------------------
// led_pattern_engine
//   Drives NUM_LEDS outputs with one of four step patterns (shift, bounce,
//   blink, count). The step rate comes from a prescaler that produces a base
//   tick every TICK_DIV clocks. A step counter then fires a step event after
//   (delay+1) ticks. The delay register saturates and is adjusted by one-shot
//   faster/slower pulses. Pause freezes the prescaler, the step counter and
//   the LEDs. mode_next advances the pattern and restarts it from its initial
//   LED value.
//
// Ports
//   clk        in   1         system clock
//   reset      in   1         asynchronous, active-high reset
//   faster     in   1         one-shot pulse: delay-1, saturating at 0
//   slower     in   1         one-shot pulse: delay+1, saturating at max
//   pause      in   1         one-shot pulse: toggle paused
//   mode_next  in   1         one-shot pulse: advance mode (3 wraps to 0)
//   delay      out  DELAY_W   current delay register
//   mode       out  2         0=SHIFT 1=BOUNCE 2=BLINK 3=COUNT
//   paused     out  1         high while stepping is frozen
//   led        out  NUM_LEDS  registered pattern output
// -----------------------------------------------------------------------------
module led_pattern_engine #(
  parameter int NUM_LEDS   = 4,
  parameter int DELAY_W    = 4,
  parameter int DELAY_INIT = 8,
  parameter int TICK_DIV   = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                faster,
  input  logic                slower,
  input  logic                pause,
  input  logic                mode_next,
  output logic [DELAY_W-1:0]  delay,
  output logic [1:0]          mode,
  output logic                paused,
  output logic [NUM_LEDS-1:0] led
);

  localparam logic [1:0] MODE_SHIFT  = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  localparam int                  PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [DELAY_W-1:0]  DELAY_MAX = '1;
  localparam logic [NUM_LEDS-1:0] LED_ONE   = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] LED_MSB   = LED_ONE << (NUM_LEDS - 1);

  logic [PRE_W-1:0]    pre_cnt;
  logic [DELAY_W-1:0]  step_cnt;
  logic                dir_down;
  logic                tick;
  logic                step;
  logic [1:0]          mode_succ;
  logic [NUM_LEDS-1:0] led_stepped;
  logic                dir_stepped;

  // Tick and step are combinational so the LED update lands on the same edge
  // that wraps the prescaler; the new pattern is visible one cycle after tick.
  assign tick      = !paused && (pre_cnt == PRE_LAST);
  assign step      = tick && (step_cnt >= delay);
  assign mode_succ = mode + 2'd1;

  // Next LED value and bounce direction if a step event occurs this cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    led_stepped = led;
    dir_stepped = dir_down;
    case (mode)
      // Rotate left; the right-shift term carries the MSB back into bit 0
      // and also covers the single-LED case.
      MODE_SHIFT: led_stepped = (led << 1) | (led >> (NUM_LEDS - 1));
      MODE_BOUNCE: begin
        if (NUM_LEDS > 1) begin
          if (!dir_down) begin
            if (led == LED_MSB) begin
              led_stepped = led >> 1;
              dir_stepped = 1'b1;
            end else begin
              led_stepped = led << 1;
            end
          end else begin
            if (led == LED_ONE) begin
              led_stepped = led << 1;
              dir_stepped = 1'b0;
            end else begin
              led_stepped = led >> 1;
            end
          end
        end
      end
      MODE_BLINK: led_stepped = ~led;
      default:    led_stepped = led + LED_ONE;
    endcase
  end

  // NOTE: only plain registers here, so all of them take the async reset;
  // non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delay    <= DELAY_W'(DELAY_INIT);
      mode     <= MODE_SHIFT;
      paused   <= 1'b0;
      led      <= LED_ONE;
      dir_down <= 1'b0;
      pre_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      // Opposing pulses in the same cycle cancel.
      if (faster && !slower && (delay != '0)) begin
        delay <= delay - 1'b1;
      end else if (slower && !faster && (delay != DELAY_MAX)) begin
        delay <= delay + 1'b1;
      end

      // Toggle uses the pre-edge value, so a step in the same cycle still
      // lands before the freeze takes effect.
      if (pause) begin
        paused <= !paused;
      end

      if (mode_next) begin
        // Mode change overrides any same-cycle step and restarts the period.
        mode     <= mode_succ;
        pre_cnt  <= '0;
        step_cnt <= '0;
        dir_down <= 1'b0;
        led      <= (mode_succ == MODE_BLINK || mode_succ == MODE_COUNT) ? '0 : LED_ONE;
      end else if (!paused) begin
        pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
        if (tick) begin
          step_cnt <= step ? '0 : step_cnt + DELAY_W'(1);
        end
        if (step) begin
          led      <= led_stepped;
          dir_down <= dir_stepped;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_engine
//   Scenario bench for led_pattern_engine with NUM_LEDS=4, DELAY_W=4,
//   DELAY_INIT=1, TICK_DIV=2. The reference model tracks the elapsed
//   unpaused cycles since the last step and a pattern position index. It
//   derives the prescaler phase and the completed ticks from that count by
//   division. Each pattern is an index-to-LED mapping.
// -----------------------------------------------------------------------------
module tb_led_pattern_engine;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int DI = 1;
  localparam int TD = 2;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          faster = 1'b0;
  logic          slower = 1'b0;
  logic          pause = 1'b0;
  logic          mode_next = 1'b0;
  logic [DW-1:0] delay;
  logic [1:0]    mode;
  logic          paused;
  logic [N-1:0]  led;

  int errors = 0;
  int checks = 0;

  led_pattern_engine #(
    .NUM_LEDS  (N),
    .DELAY_W   (DW),
    .DELAY_INIT(DI),
    .TICK_DIV  (TD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .faster   (faster),
    .slower   (slower),
    .pause    (pause),
    .mode_next(mode_next),
    .delay    (delay),
    .mode     (mode),
    .paused   (paused),
    .led      (led)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_delay, m_mode, m_elapsed, m_pos, m_cnt;
  bit m_paused, m_blink, m_step;

  function automatic logic [N-1:0] model_led();
    int p;
    case (m_mode)
      0: return N'(1 << m_pos);
      1: begin
        p = (m_pos < N) ? m_pos : (2 * N - 2 - m_pos);
        return N'(1 << p);
      end
      2: return m_blink ? {N{1'b1}} : {N{1'b0}};
      default: return N'(m_cnt);
    endcase
  endfunction

  function automatic logic [DW+2+1+N-1:0] model_vec();
    return {DW'(m_delay), 2'(m_mode), m_paused, model_led()};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_delay = DI; m_mode = 0; m_paused = 0; m_elapsed = 0;
      m_pos = 0; m_cnt = 0; m_blink = 0;
    end else begin
      m_step = !m_paused && (m_elapsed % TD == TD - 1) && (m_elapsed / TD >= m_delay);
      if (mode_next) begin
        m_mode = (m_mode + 1) % 4;
        m_pos = 0; m_cnt = 0; m_blink = 0; m_elapsed = 0;
      end else if (!m_paused) begin
        if (m_step) begin
          m_elapsed = 0;
          case (m_mode)
            0: m_pos = (m_pos + 1) % N;
            1: m_pos = (m_pos + 1) % (2 * N - 2);
            2: m_blink = !m_blink;
            default: m_cnt = (m_cnt + 1) % (1 << N);
          endcase
        end else begin
          m_elapsed++;
        end
      end
      if (pause) m_paused = !m_paused;
      if (faster && !slower && m_delay > 0) m_delay--;
      else if (slower && !faster && m_delay < DMAX) m_delay++;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; holds the pulses across one posedge, returns at the
  // next negedge with all pulses low.
  task automatic tick_in(input logic f, input logic s, input logic p, input logic m);
    faster = f; slower = s; pause = p; mode_next = m;
    @(posedge clk);
    @(negedge clk);
    faster = 1'b0; slower = 1'b0; pause = 1'b0; mode_next = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({delay, mode, paused, led} !== {4'd1, 2'd0, 1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL reset_values: got delay=%0d mode=%0d paused=%0b led=%b want delay=1 mode=0 paused=0 led=0001",
               delay, mode, paused, led);
    end
  endtask

  task automatic test_shift();
    logic [N-1:0] exp;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      repeat (4) tick_in(0, 0, 0, 0);
      exp = N'(1 << (k % N));
      checks++;
      if (led !== exp || {delay, mode, paused, led} !== model_vec()) begin
        errors++;
        $display("FAIL shift_step%0d: got led=%b state=%h want led=%b state=%h",
                 k, led, {delay, mode, paused, led}, exp, model_vec());
      end
    end
  endtask

  task automatic test_delay();
    do_reset();
    repeat (20) tick_in(0, 1, 0, 0);
    checks++;
    if (delay !== 4'd15) begin
      errors++;
      $display("FAIL delay_sat_max: got %0d want 15", delay);
    end
    repeat (20) tick_in(1, 0, 0, 0);
    checks++;
    if (delay !== 4'd0) begin
      errors++;
      $display("FAIL delay_sat_min: got %0d want 0", delay);
    end
    tick_in(1, 1, 0, 0);
    checks++;
    if (delay !== 4'd0) begin
      errors++;
      $display("FAIL delay_both_at0: got %0d want 0", delay);
    end
    tick_in(0, 1, 0, 0);
    tick_in(0, 1, 0, 0);
    tick_in(1, 1, 0, 0);
    checks++;
    if (delay !== 4'd2 || {delay, mode, paused, led} !== model_vec()) begin
      errors++;
      $display("FAIL delay_both_mid: got delay=%0d state=%h want delay=2 state=%h",
               delay, {delay, mode, paused, led}, model_vec());
    end
  endtask

  task automatic test_bounce();
    logic [N-1:0] seq [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    do_reset();
    tick_in(0, 0, 0, 1);
    checks++;
    if (mode !== 2'd1 || led !== 4'b0001) begin
      errors++;
      $display("FAIL bounce_enter: got mode=%0d led=%b want mode=1 led=0001", mode, led);
    end
    for (int k = 0; k < 6; k++) begin
      repeat (4) tick_in(0, 0, 0, 0);
      checks++;
      if (led !== seq[k] || {delay, mode, paused, led} !== model_vec()) begin
        errors++;
        $display("FAIL bounce_step%0d: got led=%b want led=%b model=%h", k, led, seq[k], model_vec());
      end
    end
  endtask

  task automatic test_count_blink();
    do_reset();
    repeat (3) tick_in(0, 0, 0, 1);
    checks++;
    if (mode !== 2'd3 || led !== 4'b0000) begin
      errors++;
      $display("FAIL count_enter: got mode=%0d led=%b want mode=3 led=0000", mode, led);
    end
    for (int k = 1; k <= 17; k++) begin
      repeat (4) tick_in(0, 0, 0, 0);
      checks++;
      if (led !== N'(k % 16) || {delay, mode, paused, led} !== model_vec()) begin
        errors++;
        $display("FAIL count_step%0d: got led=%b want led=%b", k, led, N'(k % 16));
      end
    end
    do_reset();
    repeat (2) tick_in(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (led !== ((k % 2 == 0) ? 4'b0000 : 4'b1111) || mode !== 2'd2) begin
        errors++;
        $display("FAIL blink_step%0d: got mode=%0d led=%b want mode=2 led=%b",
                 k, mode, led, (k % 2 == 0) ? 4'b0000 : 4'b1111);
      end
      repeat (4) tick_in(0, 0, 0, 0);
    end
  endtask

  task automatic test_pause();
    do_reset();
    repeat (5) tick_in(0, 0, 0, 0);
    tick_in(0, 0, 1, 0);
    for (int k = 0; k < 40; k++) begin
      tick_in(0, 0, 0, 0);
      if (k % 10 == 9) begin
        checks++;
        if (led !== 4'b0010 || paused !== 1'b1) begin
          errors++;
          $display("FAIL pause_hold%0d: got led=%b paused=%0b want led=0010 paused=1", k, led, paused);
        end
      end
    end
    tick_in(0, 0, 1, 0);
    tick_in(0, 0, 0, 0);
    checks++;
    if (led !== 4'b0010 || paused !== 1'b0) begin
      errors++;
      $display("FAIL pause_resume_early: got led=%b paused=%0b want led=0010 paused=0", led, paused);
    end
    tick_in(0, 0, 0, 0);
    checks++;
    if (led !== 4'b0100 || {delay, mode, paused, led} !== model_vec()) begin
      errors++;
      $display("FAIL pause_resume_step: got led=%b want led=0100 (remaining count only)", led);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (6) tick_in(0, 1, 0, 0);
    repeat (3) tick_in(0, 0, 0, 1);
    repeat (9) tick_in(0, 0, 0, 0);
    tick_in(0, 0, 1, 0);
    checks++;
    if ({delay, mode, paused} !== {4'd7, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_setup: got delay=%0d mode=%0d paused=%0b want delay=7 mode=3 paused=1",
               delay, mode, paused);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({delay, mode, paused, led} !== {4'd1, 2'd0, 1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL reset_mid_async: got delay=%0d mode=%0d paused=%0b led=%b want delay=1 mode=0 paused=0 led=0001",
               delay, mode, paused, led);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        tick_in($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
      end
      checks++;
      if ({delay, mode, paused, led} !== model_vec()) begin
        errors++;
        if (bad < 10) begin
          $display("FAIL random_cycle%0d: got state=%h want state=%h", k, {delay, mode, paused, led}, model_vec());
        end
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_delay();
    test_bounce();
    test_count_blink();
    test_pause();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
